mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port, word-addressed `memory` block between two requesters: port 0 (instruction fetch) and port 1 (load/store unit). It serialises requests onto the memory's read/write ports and never asserts read and write together. It returns read data and the memory error code to the issuing port. It latches the first memory error and can optionally halt all traffic until software clears it.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory state codes, arbiter FSM states and port indices
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_OK    = 2'd0,
      MEM_RW    = 2'd1,
      MEM_OOB   = 2'd2,
      MEM_ALIGN = 2'd3
   } mem_state_e;

   typedef enum logic {
      ARB_RUN    = 1'b0,
      ARB_HALTED = 1'b1
   } arb_state_e;

   localparam int PORT_IF  = 0;
   localparam int PORT_LSU = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshakes and memory port bundle for mem_arbiter
interface mem_arbiter_if;
   logic        p0_req_valid, p1_req_valid;
   logic        p0_req_ready, p1_req_ready;
   logic        p0_req_we,    p1_req_we;
   logic [31:0] p0_req_addr,  p1_req_addr;
   logic [31:0] p0_req_wdata, p1_req_wdata;
   logic        p0_rsp_valid, p1_rsp_valid;
   logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
   logic [1:0]  p0_rsp_err,   p1_rsp_err;
   logic        mem_r_en, mem_w_en;
   logic [31:0] mem_r_addr, mem_w_addr, mem_w_data;
   logic [31:0] mem_r_data;
   logic [1:0]  mem_state;

   modport slave (
      input  p0_req_valid, p1_req_valid, p0_req_we, p1_req_we,
             p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata,
             mem_r_data, mem_state,
      output p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
             p0_rsp_rdata, p1_rsp_rdata, p0_rsp_err, p1_rsp_err,
             mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data
   );

   modport master (
      output p0_req_valid, p1_req_valid, p0_req_we, p1_req_we,
             p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata,
             mem_r_data, mem_state,
      input  p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
             p0_rsp_rdata, p1_rsp_rdata, p0_rsp_err, p1_rsp_err,
             mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data
   );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way pick, round-robin or fixed port-0 priority
import mem_pkg::*;

module mem_arb_pick #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = 2'b00;
         // On conflict the port that did not win last time goes first
         if (ROUND_ROBIN && last_grant == 1'(PORT_IF))
            grant[PORT_LSU] = 1'b1;
         else
            grant[PORT_IF] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of the single-port word memory,
// with one-cycle responses and a sticky first-error latch that can halt traffic
import mem_pkg::*;

module mem_arbiter #(
   parameter string NAME          = "",
   parameter bit    ROUND_ROBIN   = 1'b1,
   parameter bit    HALT_ON_ERROR = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          err_valid,
   output logic [1:0]    err_code,
   output logic          err_port,
   output logic [31:0]   err_addr,
   input  logic          err_clear
);

   localparam logic [0:0] ST_RUN    = 1'(ARB_RUN);
   localparam logic [0:0] ST_HALTED = 1'(ARB_HALTED);

   logic [0:0]  state;
   logic        last_grant;
   logic [1:0]  pick_grant, grant;
   logic        issue, sel, iss_we;
   logic [31:0] iss_addr, iss_wdata;
   logic        tag_valid, tag_port, tag_we;
   logic [31:0] tag_addr;
   logic [31:0] rsp_rdata;
   logic        new_err;

   mem_arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
      .valid      ({bus.p1_req_valid, bus.p0_req_valid}),
      .last_grant (last_grant),
      .grant      (pick_grant)
   );

   assign grant  = (state == ST_RUN && !rst) ? pick_grant : 2'b00;
   assign issue  = |grant;
   assign sel    = grant[PORT_LSU];
   assign iss_we    = sel ? bus.p1_req_we    : bus.p0_req_we;
   assign iss_addr  = sel ? bus.p1_req_addr  : bus.p0_req_addr;
   assign iss_wdata = sel ? bus.p1_req_wdata : bus.p0_req_wdata;

   assign bus.p0_req_ready = grant[PORT_IF];
   assign bus.p1_req_ready = grant[PORT_LSU];

   assign bus.mem_r_en   = issue & ~iss_we;
   assign bus.mem_w_en   = issue &  iss_we;
   assign bus.mem_r_addr = bus.mem_r_en ? iss_addr  : 32'd0;
   assign bus.mem_w_addr = bus.mem_w_en ? iss_addr  : 32'd0;
   assign bus.mem_w_data = bus.mem_w_en ? iss_wdata : 32'd0;

   // mem_state is only meaningful in the cycle after an issue
   assign rsp_rdata        = (tag_valid && !tag_we) ? bus.mem_r_data : 32'd0;
   assign bus.p0_rsp_valid = tag_valid && (tag_port == 1'(PORT_IF));
   assign bus.p1_rsp_valid = tag_valid && (tag_port == 1'(PORT_LSU));
   assign bus.p0_rsp_rdata = bus.p0_rsp_valid ? rsp_rdata : 32'd0;
   assign bus.p1_rsp_rdata = bus.p1_rsp_valid ? rsp_rdata : 32'd0;
   assign bus.p0_rsp_err   = bus.p0_rsp_valid ? bus.mem_state : 2'd0;
   assign bus.p1_rsp_err   = bus.p1_rsp_valid ? bus.mem_state : 2'd0;

   assign new_err = tag_valid && (bus.mem_state != MEM_OK) && (!err_valid || err_clear);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         last_grant <= 1'(PORT_LSU);
         tag_valid  <= 1'b0;
         tag_port   <= 1'b0;
         tag_we     <= 1'b0;
         tag_addr   <= 32'd0;
         err_valid  <= 1'b0;
         err_code   <= 2'd0;
         err_port   <= 1'b0;
         err_addr   <= 32'd0;
      end else begin
         tag_valid <= issue;
         if (issue) begin
            tag_port   <= sel;
            tag_we     <= iss_we;
            tag_addr   <= iss_addr;
            last_grant <= sel;
         end
         if (new_err) begin
            err_valid <= 1'b1;
            err_code  <= bus.mem_state;
            err_port  <= tag_port;
            err_addr  <= tag_addr;
         end else if (err_clear) begin
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            err_port  <= 1'b0;
            err_addr  <= 32'd0;
         end
         if (new_err && HALT_ON_ERROR)
            state <= ST_HALTED;
         else if (err_clear)
            state <= ST_RUN;
      end
   end

   a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(bus.mem_r_en && bus.mem_w_en))
      else $error("%s: memory read and write enables both high", NAME);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench: per-cycle reference model plus directed vectors
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter_if bus0();
   mem_arbiter_if bus1();

   logic        req_valid [2][2];
   logic        req_we    [2][2];
   logic [31:0] req_addr  [2][2];
   logic [31:0] req_wdata [2][2];
   logic        ready     [2][2];
   logic        rsp_valid [2][2];
   logic [31:0] rsp_rdata [2][2];
   logic [1:0]  rsp_err   [2][2];
   logic        r_en [2], w_en [2];
   logic [31:0] r_addr [2], w_addr [2], w_data [2];
   logic [31:0] m_rdata [2] = '{default: 32'd0};
   logic [1:0]  m_state [2] = '{default: 2'd0};
   logic        err_valid [2];
   logic [1:0]  err_code [2];
   logic        err_port [2];
   logic [31:0] err_addr [2];
   logic        err_clear [2];

   assign bus0.p0_req_valid = req_valid[0][0];  assign bus0.p1_req_valid = req_valid[0][1];
   assign bus0.p0_req_we    = req_we[0][0];     assign bus0.p1_req_we    = req_we[0][1];
   assign bus0.p0_req_addr  = req_addr[0][0];   assign bus0.p1_req_addr  = req_addr[0][1];
   assign bus0.p0_req_wdata = req_wdata[0][0];  assign bus0.p1_req_wdata = req_wdata[0][1];
   assign bus0.mem_r_data   = m_rdata[0];       assign bus0.mem_state    = m_state[0];
   assign ready[0][0]     = bus0.p0_req_ready;  assign ready[0][1]     = bus0.p1_req_ready;
   assign rsp_valid[0][0] = bus0.p0_rsp_valid;  assign rsp_valid[0][1] = bus0.p1_rsp_valid;
   assign rsp_rdata[0][0] = bus0.p0_rsp_rdata;  assign rsp_rdata[0][1] = bus0.p1_rsp_rdata;
   assign rsp_err[0][0]   = bus0.p0_rsp_err;    assign rsp_err[0][1]   = bus0.p1_rsp_err;
   assign r_en[0] = bus0.mem_r_en;  assign w_en[0] = bus0.mem_w_en;
   assign r_addr[0] = bus0.mem_r_addr;  assign w_addr[0] = bus0.mem_w_addr;  assign w_data[0] = bus0.mem_w_data;

   assign bus1.p0_req_valid = req_valid[1][0];  assign bus1.p1_req_valid = req_valid[1][1];
   assign bus1.p0_req_we    = req_we[1][0];     assign bus1.p1_req_we    = req_we[1][1];
   assign bus1.p0_req_addr  = req_addr[1][0];   assign bus1.p1_req_addr  = req_addr[1][1];
   assign bus1.p0_req_wdata = req_wdata[1][0];  assign bus1.p1_req_wdata = req_wdata[1][1];
   assign bus1.mem_r_data   = m_rdata[1];       assign bus1.mem_state    = m_state[1];
   assign ready[1][0]     = bus1.p0_req_ready;  assign ready[1][1]     = bus1.p1_req_ready;
   assign rsp_valid[1][0] = bus1.p0_rsp_valid;  assign rsp_valid[1][1] = bus1.p1_rsp_valid;
   assign rsp_rdata[1][0] = bus1.p0_rsp_rdata;  assign rsp_rdata[1][1] = bus1.p1_rsp_rdata;
   assign rsp_err[1][0]   = bus1.p0_rsp_err;    assign rsp_err[1][1]   = bus1.p1_rsp_err;
   assign r_en[1] = bus1.mem_r_en;  assign w_en[1] = bus1.mem_w_en;
   assign r_addr[1] = bus1.mem_r_addr;  assign w_addr[1] = bus1.mem_w_addr;  assign w_data[1] = bus1.mem_w_data;

   mem_arbiter #(.NAME("arb_rr_halt"), .ROUND_ROBIN(1'b1), .HALT_ON_ERROR(1'b1)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .err_valid(err_valid[0]), .err_code(err_code[0]), .err_port(err_port[0]),
      .err_addr(err_addr[0]), .err_clear(err_clear[0])
   );

   mem_arbiter #(.NAME("arb_fixed_nohalt"), .ROUND_ROBIN(1'b0), .HALT_ON_ERROR(1'b0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .err_valid(err_valid[1]), .err_code(err_code[1]), .err_port(err_port[1]),
      .err_addr(err_addr[1]), .err_clear(err_clear[1])
   );

   function automatic logic [1:0] code_of(input logic [31:0] a);
      if (a >= 32'h1000) return 2'd2;
      if (a[1:0] != 2'b00) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [31:0] init_word(input int w);
      return (w == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(w) * 32'd3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory stand-in: 1024 words, registered read data and state that hold while idle
   logic [31:0] mem_env [2][1024];
   logic        env_loaded = 1'b0;
   always @(posedge clk) begin
      if (!env_loaded) begin
         for (int i = 0; i < 2; i++)
            for (int w = 0; w < 1024; w++) mem_env[i][w] <= init_word(w);
         env_loaded <= 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_en[i]) begin
               m_state[i] <= code_of(r_addr[i]);
               m_rdata[i] <= (code_of(r_addr[i]) == 2'd0) ? mem_env[i][r_addr[i][11:2]] : 32'd0;
            end else if (w_en[i]) begin
               m_state[i] <= code_of(w_addr[i]);
               if (code_of(w_addr[i]) == 2'd0) mem_env[i][w_addr[i][11:2]] <= w_data[i];
            end
         end
      end
   end

   // Reference model: decides the winner and the pending response from the rules alone
   logic        m_halted [2], m_last [2], m_pend [2], m_pwe [2], m_ev [2], m_eport [2];
   int          m_pport [2];
   logic [31:0] m_paddr [2], m_eaddr [2];
   logic [1:0]  m_ecode [2];
   logic [31:0] ref_mem [2][1024];

   initial begin
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 1024; w++) ref_mem[i][w] = init_word(w);
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            int         win;
            logic       rr, halt_on, rd, wr;
            logic [1:0] c;
            string      tg;
            rr = (i == 0);
            halt_on = (i == 0);
            tg = $sformatf("m%0d", i);
            if (rst) begin
               for (int p = 0; p < 2; p++) begin
                  chk({tg, "_rst_ready"}, 32'(ready[i][p]), 32'd0);
                  chk({tg, "_rst_rsp_valid"}, 32'(rsp_valid[i][p]), 32'd0);
               end
               chk({tg, "_rst_r_en"}, 32'(r_en[i]), 32'd0);
               chk({tg, "_rst_w_en"}, 32'(w_en[i]), 32'd0);
               chk({tg, "_rst_addrs"}, r_addr[i] | w_addr[i] | w_data[i], 32'd0);
               chk({tg, "_rst_err"}, {err_addr[i][28:0], err_code[i], err_port[i]} | 32'(err_valid[i]), 32'd0);
               m_halted[i] = 1'b0; m_last[i] = 1'b1; m_pend[i] = 1'b0;
               m_ev[i] = 1'b0; m_ecode[i] = 2'd0; m_eport[i] = 1'b0; m_eaddr[i] = 32'd0;
            end else begin
               win = -1;
               if (!m_halted[i]) begin
                  if (req_valid[i][0] && req_valid[i][1]) win = rr ? 1 - int'(m_last[i]) : 0;
                  else if (req_valid[i][0]) win = 0;
                  else if (req_valid[i][1]) win = 1;
               end
               for (int p = 0; p < 2; p++)
                  chk($sformatf("%s_ready_p%0d", tg, p), 32'(ready[i][p]), 32'(win == p));
               wr = (win >= 0) && req_we[i][win];
               rd = (win >= 0) && !req_we[i][win];
               chk({tg, "_r_en"}, 32'(r_en[i]), 32'(rd));
               chk({tg, "_w_en"}, 32'(w_en[i]), 32'(wr));
               chk({tg, "_r_addr"}, r_addr[i], rd ? req_addr[i][win] : 32'd0);
               chk({tg, "_w_addr"}, w_addr[i], wr ? req_addr[i][win] : 32'd0);
               chk({tg, "_w_data"}, w_data[i], wr ? req_wdata[i][win] : 32'd0);
               c = m_pend[i] ? code_of(m_paddr[i]) : 2'd0;
               for (int p = 0; p < 2; p++) begin
                  chk($sformatf("%s_rsp_valid_p%0d", tg, p), 32'(rsp_valid[i][p]), 32'(m_pend[i] && m_pport[i] == p));
                  if (m_pend[i] && m_pport[i] == p) begin
                     chk($sformatf("%s_rsp_err_p%0d", tg, p), 32'(rsp_err[i][p]), 32'(c));
                     chk($sformatf("%s_rsp_rdata_p%0d", tg, p), rsp_rdata[i][p],
                         (m_pwe[i] || c != 2'd0) ? 32'd0 : ref_mem[i][m_paddr[i][11:2]]);
                  end
               end
               chk({tg, "_err_valid"}, 32'(err_valid[i]), 32'(m_ev[i]));
               chk({tg, "_err_code"}, 32'(err_code[i]), 32'(m_ecode[i]));
               chk({tg, "_err_port"}, 32'(err_port[i]), 32'(m_eport[i]));
               chk({tg, "_err_addr"}, err_addr[i], m_eaddr[i]);
               if (m_pend[i] && c != 2'd0 && (!m_ev[i] || err_clear[i])) begin
                  m_ev[i] = 1'b1; m_ecode[i] = c; m_eport[i] = m_pport[i][0]; m_eaddr[i] = m_paddr[i];
                  if (halt_on) m_halted[i] = 1'b1;
               end else if (err_clear[i]) begin
                  m_ev[i] = 1'b0; m_ecode[i] = 2'd0; m_eport[i] = 1'b0; m_eaddr[i] = 32'd0;
                  m_halted[i] = 1'b0;
               end
               m_pend[i] = (win >= 0);
               if (win >= 0) begin
                  m_pport[i] = win;
                  m_pwe[i] = req_we[i][win];
                  m_paddr[i] = req_addr[i][win];
                  m_last[i] = win[0];
                  if (wr && code_of(req_addr[i][win]) == 2'd0)
                     ref_mem[i][req_addr[i][win][11:2]] = req_wdata[i][win];
               end
            end
         end
      end
   end

   task automatic set_req(input int i, input int p, input logic v, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
      req_valid[i][p] = v; req_we[i][p] = we; req_addr[i][p] = a; req_wdata[i][p] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic read1(input int i, input int p, input logic [31:0] a,
                        input logic [31:0] exp_data, input logic [1:0] exp_err, input string nm);
      set_req(i, p, 1'b1, 1'b0, a, 32'd0);
      @(negedge clk);
      chk({nm, "_ready"}, 32'(ready[i][p]), 32'd1);
      next_cycle();
      set_req(i, p, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk({nm, "_rsp_valid"}, 32'(rsp_valid[i][p]), 32'd1);
      chk({nm, "_rdata"}, rsp_rdata[i][p], exp_data);
      chk({nm, "_err"}, 32'(rsp_err[i][p]), 32'(exp_err));
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         err_clear[i] = 1'b0;
         for (int p = 0; p < 2; p++) set_req(i, p, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      next_cycle();

      // Round-robin conflict: p0 reads 0x0, p1 writes 0x55 to 0x4
      set_req(0, 0, 1'b1, 1'b0, 32'h0, 32'd0);
      set_req(0, 1, 1'b1, 1'b1, 32'h4, 32'h55);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("rr_grant_p0_c%0d", k), 32'(ready[0][0]), 32'(k % 2 == 0));
         chk($sformatf("rr_grant_p1_c%0d", k), 32'(ready[0][1]), 32'(k % 2 == 1));
         next_cycle();
      end
      set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      next_cycle();

      read1(0, 0, 32'h10, 32'hDEADBEEF, 2'd0, "rd_0x10");
      read1(0, 0, 32'h4, 32'h55, 2'd0, "rd_back_0x4");

      // Fixed priority: port 1 never wins a conflict
      set_req(1, 0, 1'b1, 1'b0, 32'h0, 32'd0);
      set_req(1, 1, 1'b1, 1'b1, 32'h4, 32'h55);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("fixed_grant_p0_c%0d", k), 32'(ready[1][0]), 32'd1);
         chk($sformatf("fixed_grant_p1_c%0d", k), 32'(ready[1][1]), 32'd0);
         next_cycle();
      end
      set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      next_cycle();

      // Misaligned read halts the round-robin instance until err_clear
      set_req(0, 1, 1'b1, 1'b0, 32'h6, 32'd0);
      @(negedge clk);
      chk("align_ready", 32'(ready[0][1]), 32'd1);
      next_cycle();
      set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("align_rsp_valid", 32'(rsp_valid[0][1]), 32'd1);
      chk("align_rsp_err", 32'(rsp_err[0][1]), 32'd3);
      next_cycle();
      set_req(0, 0, 1'b1, 1'b0, 32'h0, 32'd0);
      @(negedge clk);
      chk("latch_valid", 32'(err_valid[0]), 32'd1);
      chk("latch_code", 32'(err_code[0]), 32'd3);
      chk("latch_port", 32'(err_port[0]), 32'd1);
      chk("latch_addr", err_addr[0], 32'h6);
      chk("halted_ready_a", 32'(ready[0][0]), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("halted_ready_b", 32'(ready[0][0]), 32'd0);
      next_cycle();
      err_clear[0] = 1'b1;
      @(negedge clk);
      chk("clear_cycle_ready", 32'(ready[0][0]), 32'd0);
      next_cycle();
      err_clear[0] = 1'b0;
      @(negedge clk);
      chk("resume_ready", 32'(ready[0][0]), 32'd1);
      chk("cleared_valid", 32'(err_valid[0]), 32'd0);
      next_cycle();
      set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("resume_rsp_err", 32'(rsp_err[0][0]), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("no_relatch", 32'(err_valid[0]), 32'd0);
      next_cycle();

      // Reset while a read is in flight drops the response
      set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'd0);
      @(negedge clk);
      chk("rst_issue_ready", 32'(ready[0][0]), 32'd1);
      next_cycle();
      set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid[0][0]), 32'd0);
      chk("rst_r_en", 32'(r_en[0]), 32'd0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // Back-to-back errors without halting: the first one sticks
      set_req(1, 0, 1'b1, 1'b0, 32'h100000, 32'd0);
      @(negedge clk);
      chk("oob_ready", 32'(ready[1][0]), 32'd1);
      next_cycle();
      set_req(1, 0, 1'b1, 1'b0, 32'h2, 32'd0);
      @(negedge clk);
      chk("unal_ready", 32'(ready[1][0]), 32'd1);
      chk("oob_rsp_err", 32'(rsp_err[1][0]), 32'd2);
      next_cycle();
      set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("unal_rsp_err", 32'(rsp_err[1][0]), 32'd3);
      chk("first_code_a", 32'(err_code[1]), 32'd2);
      chk("first_addr_a", err_addr[1], 32'h100000);
      next_cycle();
      @(negedge clk);
      chk("first_code_b", 32'(err_code[1]), 32'd2);
      chk("first_addr_b", err_addr[1], 32'h100000);
      chk("first_valid_b", 32'(err_valid[1]), 32'd1);
      next_cycle();

      repeat (2) next_cycle();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
